// File: rtl/peecc_pkg.sv
// rtl/peecc_pkg.sv - shared UART framing constants and FSM state types for the PEECC pipeline
package peecc_pkg;

   localparam logic       START_BIT      = 1'b0;
   localparam logic       STOP_BIT       = 1'b1;
   localparam int         DATA_BITS      = 8;
   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT,
      FINISH
   } top_state_t;

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } byte_state_t;

endpackage

// File: rtl/result_uart_tx_if.sv
// rtl/result_uart_tx_if.sv - controller <-> result reporter handshake and UART line
interface result_uart_tx_if #(
   parameter int NUM_BYTES = 8
) ();

   logic                   start_tx;
   logic [NUM_BYTES*8-1:0] results;
   logic                   tx_serial;
   logic                   tx_busy;
   logic                   tx_finish;

   modport master (
      output start_tx,
      output results,
      input  tx_serial,
      input  tx_busy,
      input  tx_finish
   );

   modport slave (
      input  start_tx,
      input  results,
      output tx_serial,
      output tx_busy,
      output tx_finish
   );

endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with a one-deep hold slot for gapless chaining
module uart_tx_byte
   import peecc_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic [7:0] data,
   output logic       tx_serial,
   output logic       byte_busy,
   output logic       byte_done
);

   localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   byte_state_t   state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    sh;
   logic [7:0]    hold;
   logic          pend;

   // High during the final cycle of the stop bit, so the sequencer can react on the same edge the line goes idle.
   assign byte_done = (state == B_STOP) && (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= B_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         sh        <= '0;
         hold      <= '0;
         pend      <= 1'b0;
         tx_serial <= STOP_BIT;
         byte_busy <= 1'b0;
      end else begin
         // A go while a byte is on the line is parked and picked up right after the stop bit.
         if (go && state != B_IDLE) begin
            pend <= 1'b1;
            hold <= data;
         end
         case (state)
            B_IDLE: begin
               if (go) begin
                  sh        <= data;
                  cnt       <= CNT_MAX;
                  tx_serial <= START_BIT;
                  byte_busy <= 1'b1;
                  state     <= B_START;
               end
            end
            B_START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt       <= CNT_MAX;
                  bit_idx   <= '0;
                  tx_serial <= sh[0];
                  state     <= B_DATA;
               end
            end
            B_DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt <= CNT_MAX;
                  if (bit_idx == 3'(DATA_BITS - 1)) begin
                     tx_serial <= STOP_BIT;
                     state     <= B_STOP;
                  end else begin
                     bit_idx   <= bit_idx + 1'b1;
                     sh        <= {1'b0, sh[7:1]};
                     tx_serial <= sh[1];
                  end
               end
            end
            B_STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (pend) begin
                  pend      <= 1'b0;
                  sh        <= hold;
                  cnt       <= CNT_MAX;
                  tx_serial <= START_BIT;
                  state     <= B_START;
               end else begin
                  tx_serial <= STOP_BIT;
                  byte_busy <= 1'b0;
                  state     <= B_IDLE;
               end
            end
            default: state <= B_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - frames the result word as HEADER + payload bytes over 8N1 UART
module result_uart_tx
   import peecc_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 868,
   parameter int         NUM_BYTES    = 8,
   parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
   input logic            clk,
   input logic            reset,
   result_uart_tx_if.slave bus
);

   localparam int            IW       = $clog2(NUM_BYTES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES);

   top_state_t             state;
   logic                   start_q;
   logic [IW-1:0]          idx;
   logic                   last_run;
   logic [NUM_BYTES*8-1:0] payload;
   logic                   go;
   logic [7:0]             byte_data;
   logic                   finish_r;
   logic                   ser_tx;
   logic                   ser_busy;
   logic                   ser_done;

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk      (clk),
      .reset    (reset),
      .go       (go),
      .data     (byte_data),
      .tx_serial(ser_tx),
      .byte_busy(ser_busy),
      .byte_done(ser_done)
   );

   assign bus.tx_serial = ser_tx;
   assign bus.tx_busy   = ser_busy;
   assign bus.tx_finish = finish_r;

   // The next byte is queued into the serializer one byte ahead; last_run marks that the final byte is on the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         idx       <= '0;
         last_run  <= 1'b0;
         payload   <= '0;
         go        <= 1'b0;
         byte_data <= '0;
         finish_r  <= 1'b0;
      end else begin
         start_q  <= bus.start_tx;
         go       <= 1'b0;
         finish_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_tx && !start_q) begin
                  payload  <= bus.results;
                  idx      <= '0;
                  last_run <= 1'b0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               go <= 1'b1;
               if (idx == '0) begin
                  byte_data <= HEADER;
               end else begin
                  byte_data <= payload[7:0];
                  payload   <= payload >> 8;
               end
               state <= SEND;
            end
            SEND: state <= WAIT;
            WAIT: begin
               if (idx == '0) begin
                  idx   <= idx + 1'b1;
                  state <= LOAD;
               end else if (ser_done) begin
                  if (idx != LAST_IDX) begin
                     idx   <= idx + 1'b1;
                     state <= LOAD;
                  end else if (!last_run) begin
                     last_run <= 1'b1;
                  end else begin
                     finish_r <= 1'b1;
                     state    <= FINISH;
                  end
               end
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - scoreboard bench decoding the UART line of result_uart_tx
module tb_result_uart_tx;

   localparam int C     = 4;
   localparam int NB    = 2;
   localparam int FRAME = (NB + 1) * 10 * C;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   result_uart_tx_if #(.NUM_BYTES(NB)) bus ();

   result_uart_tx #(
      .CLKS_PER_BIT(C),
      .NUM_BYTES   (NB),
      .HEADER      (8'hA5)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];
   int         fall_times[$];
   int         cyc = 0;
   int         mon_t = 0;
   int         mon_bytes = 0;
   bit         mon_active = 1'b0;
   logic [7:0] mon_byte = 8'h00;
   logic [7:0] exp_byte;
   int         busy_run = 0;
   int         last_busy_len = 0;
   int         busy_fall_cyc = -1;
   int         finish_count = 0;
   int         fin_first_cyc = -2;
   int         fin_len = 0;
   logic       prev_busy = 1'b0;
   logic       prev_fin = 1'b0;

   // Line decoder and scoreboard: samples at bit centres, aborts and flushes on reset.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         mon_active = 1'b0;
         exp_q.delete();
      end else if (!mon_active) begin
         if (bus.tx_serial === 1'b0) begin
            mon_active = 1'b1;
            mon_t = 0;
            fall_times.push_back(cyc);
         end
      end else begin
         mon_t++;
         if (mon_t == 2) begin
            vectors++;
            if (bus.tx_serial !== 1'b0) begin
               miscompares++;
               $display("FAIL start_bit got %b want 0 at cycle %0d", bus.tx_serial, cyc);
               mon_active = 1'b0;
            end
         end else if (mon_t >= 5 && mon_t <= 33 && ((mon_t - 5) % 4) == 0) begin
            mon_byte[(mon_t - 5) / 4] = bus.tx_serial;
         end else if (mon_t == 37) begin
            mon_active = 1'b0;
            vectors++;
            if (bus.tx_serial !== 1'b1) begin
               miscompares++;
               $display("FAIL stop_bit got %b want 1 at cycle %0d", bus.tx_serial, cyc);
            end else if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_byte got %h want none", mon_byte);
            end else begin
               exp_byte = exp_q.pop_front();
               mon_bytes++;
               if (mon_byte !== exp_byte) begin
                  miscompares++;
                  $display("FAIL byte_value got %h want %h", mon_byte, exp_byte);
               end
            end
         end
      end
      if (bus.tx_busy === 1'b1) begin
         busy_run++;
      end else if (prev_busy === 1'b1) begin
         last_busy_len = busy_run;
         busy_fall_cyc = cyc;
         busy_run = 0;
      end
      prev_busy = bus.tx_busy;
      if (bus.tx_finish === 1'b1) begin
         if (prev_fin !== 1'b1) begin
            finish_count++;
            fin_first_cyc = cyc;
            fin_len = 0;
         end
         fin_len++;
      end
      prev_fin = bus.tx_finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [15:0] res);
      bus.results  = res;
      bus.start_tx = 1'b1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(res[7:0]);
      exp_q.push_back(res[15:8]);
   endtask

   task automatic wait_finish(input int base, input int budget);
      int n = 0;
      while (finish_count == base && n < budget) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (finish_count == base) begin
         miscompares++;
         $display("FAIL finish_timeout got no tx_finish want one within %0d cycles", budget);
      end
      tick(2);
   endtask

   task automatic test_reset();
      bus.start_tx = 1'b0;
      bus.results  = '0;
      reset = 1'b1;
      tick(4);
      vectors += 3;
      if (bus.tx_serial !== 1'b1) begin miscompares++; $display("FAIL reset_tx_serial got %b want 1", bus.tx_serial); end
      if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy got %b want 0", bus.tx_busy); end
      if (bus.tx_finish !== 1'b0) begin miscompares++; $display("FAIL reset_tx_finish got %b want 0", bus.tx_finish); end
      reset = 1'b0;
      tick(3);
   endtask

   task automatic test_single_frame();
      int f0 = finish_count;
      int b0 = mon_bytes;
      launch(16'h3C81);
      repeat (3) @(negedge clk);
      vectors++;
      if (bus.tx_serial !== 1'b1) begin miscompares++; $display("FAIL latency_early got %b want 1", bus.tx_serial); end
      @(negedge clk);
      vectors += 2;
      if (bus.tx_serial !== 1'b0) begin miscompares++; $display("FAIL latency_start got %b want 0", bus.tx_serial); end
      if (bus.tx_busy !== 1'b1) begin miscompares++; $display("FAIL latency_busy got %b want 1", bus.tx_busy); end
      wait_finish(f0, 400);
      vectors += 5;
      if (last_busy_len != FRAME) begin miscompares++; $display("FAIL busy_len got %0d want %0d", last_busy_len, FRAME); end
      if (fin_len != 1) begin miscompares++; $display("FAIL finish_len got %0d want 1", fin_len); end
      if (fin_first_cyc != busy_fall_cyc) begin miscompares++; $display("FAIL finish_align got %0d want %0d", fin_first_cyc, busy_fall_cyc); end
      if (mon_bytes - b0 != 3) begin miscompares++; $display("FAIL single_bytes got %0d want 3", mon_bytes - b0); end
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_pending got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_held_start();
      int f0, b0;
      bus.start_tx = 1'b0;
      tick(3);
      f0 = finish_count;
      b0 = mon_bytes;
      launch(16'h5AC3);
      tick(300);
      vectors += 3;
      if (finish_count - f0 != 1) begin miscompares++; $display("FAIL held_finish got %0d want 1", finish_count - f0); end
      if (mon_bytes - b0 != 3) begin miscompares++; $display("FAIL held_bytes got %0d want 3", mon_bytes - b0); end
      if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL held_idle got %b want 0", bus.tx_busy); end
      bus.start_tx = 1'b0;
      tick(3);
      launch(16'h0F1E);
      wait_finish(f0 + 1, 400);
      vectors += 2;
      if (finish_count - f0 != 2) begin miscompares++; $display("FAIL rearm_finish got %0d want 2", finish_count - f0); end
      if (mon_bytes - b0 != 6) begin miscompares++; $display("FAIL rearm_bytes got %0d want 6", mon_bytes - b0); end
   endtask

   task automatic test_payload_stability();
      int f0, b0;
      bus.start_tx = 1'b0;
      tick(3);
      f0 = finish_count;
      b0 = mon_bytes;
      launch(16'h3C81);
      tick(5);
      bus.results = 16'hFFFF;
      wait_finish(f0, 400);
      vectors += 2;
      if (mon_bytes - b0 != 3) begin miscompares++; $display("FAIL stable_bytes got %0d want 3", mon_bytes - b0); end
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL stable_pending got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int f0, i0;
      bus.start_tx = 1'b0;
      tick(3);
      f0 = finish_count;
      i0 = fall_times.size();
      launch(16'h00FF);
      wait_finish(f0, 400);
      vectors++;
      if (fall_times.size() - i0 != 3) begin
         miscompares++;
         $display("FAIL b2b_starts got %0d want 3", fall_times.size() - i0);
      end else begin
         vectors += 2;
         if (fall_times[i0+1] - fall_times[i0] != 10 * C) begin
            miscompares++; $display("FAIL b2b_offset1 got %0d want %0d", fall_times[i0+1] - fall_times[i0], 10 * C);
         end
         if (fall_times[i0+2] - fall_times[i0] != 20 * C) begin
            miscompares++; $display("FAIL b2b_offset2 got %0d want %0d", fall_times[i0+2] - fall_times[i0], 20 * C);
         end
      end
   endtask

   task automatic test_mid_reset();
      int f0, b0;
      bus.start_tx = 1'b0;
      tick(3);
      f0 = finish_count;
      launch(16'hA1B2);
      tick(2);
      bus.start_tx = 1'b0;
      tick(54);
      reset = 1'b1;
      tick(1);
      vectors += 2;
      if (bus.tx_serial !== 1'b1) begin miscompares++; $display("FAIL midrst_tx got %b want 1", bus.tx_serial); end
      if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", bus.tx_busy); end
      reset = 1'b0;
      tick(200);
      vectors++;
      if (finish_count != f0) begin miscompares++; $display("FAIL midrst_finish got %0d want %0d", finish_count, f0); end
      b0 = mon_bytes;
      launch(16'h6D4E);
      wait_finish(f0, 400);
      vectors += 2;
      if (mon_bytes - b0 != 3) begin miscompares++; $display("FAIL recover_bytes got %0d want 3", mon_bytes - b0); end
      if (last_busy_len != FRAME) begin miscompares++; $display("FAIL recover_len got %0d want %0d", last_busy_len, FRAME); end
   endtask

   task automatic test_retrigger();
      int f0, b0;
      bus.start_tx = 1'b0;
      tick(3);
      f0 = finish_count;
      b0 = mon_bytes;
      launch(16'h1234);
      tick(30);
      bus.start_tx = 1'b0;
      tick(5);
      bus.start_tx = 1'b1;
      wait_finish(f0, 400);
      tick(100);
      vectors += 5;
      if (finish_count - f0 != 1) begin miscompares++; $display("FAIL retrig_finish got %0d want 1", finish_count - f0); end
      if (mon_bytes - b0 != 3) begin miscompares++; $display("FAIL retrig_bytes got %0d want 3", mon_bytes - b0); end
      if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL retrig_busy got %b want 0", bus.tx_busy); end
      if (bus.tx_serial !== 1'b1) begin miscompares++; $display("FAIL retrig_line got %b want 1", bus.tx_serial); end
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL retrig_pending got %0d want 0", exp_q.size()); end
      bus.start_tx = 1'b0;
      tick(3);
   endtask

   initial begin
      bus.start_tx = 1'b0;
      bus.results  = '0;
      test_reset();
      test_single_frame();
      test_held_start();
      test_payload_stability();
      test_back_to_back();
      test_mid_reset();
      test_retrigger();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Serial result reporter for the PEECC FPGA test pipeline. On a start request from the pipeline controller (`start_tx`), it captures the result word (transition counts, bit-flip counts, K-comparison result) and sends it as a framed 8N1 UART byte stream. When the last stop bit completes, it returns a one-cycle `tx_finish` pulse, which the controller uses to leave its report state and go back to idle.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `NUM_BYTES`, default 8: number of payload bytes per frame. Must be ≥ 1.
- `HEADER`, default 8'hA5: sync byte sent ahead of the payload.
- `clk`  in  1: system clock. The block uses this single clock only.
- `reset`  in  1: synchronous, active-high reset.
- `start_tx`  in  1: frame request from the controller. It is level-held by the controller, so only its rising edge starts a frame.
- `results`  in  NUM_BYTES*8: payload, sampled in the start cycle.
- `tx_serial`  out  1: UART line. Idles high.
- `tx_busy`  out  1: high from the first start-bit cycle through the last stop-bit cycle.
- `tx_finish`  out  1: one-cycle pulse after the final stop bit.

## Operation
- **Start detection.**
  - `start_q` registers `start_tx`.
  - Start condition: `start_tx & ~start_q` while in IDLE.
  - A rising edge in any other state is ignored. It is not queued.
- **Frame format.**
  - Frame = HEADER, then payload byte 0 (`results[7:0]`) through byte NUM_BYTES-1.
  - Each byte is sent as 1 start bit (0), 8 data bits LSB-first, then 1 stop bit (1).
  - There is no idle gap between bytes.
- **Payload capture.** `results` is copied into a shift register in the start cycle. Later changes to `results` do not affect the frame in flight.
- **Top FSM states:** IDLE, LOAD, SEND, WAIT, FINISH.
  - IDLE → LOAD on the start condition. Payload is captured and the byte index is cleared.
  - LOAD: presents the current byte to the byte serializer and pulses its `go`. Go to SEND.
  - SEND → WAIT: unconditional, one cycle.
  - WAIT: waits for the serializer's `byte_done`. If more bytes remain, increment the index and go to LOAD. After the last byte, go to FINISH.
  - FINISH: `tx_finish`=1 for one cycle, then go to IDLE.
- **Byte serializer FSM states:** B_IDLE, B_START, B_DATA, B_STOP.
  - Each bit lasts exactly CLKS_PER_BIT cycles, counted by a down-counter.
  - The bit index runs 0..7 in B_DATA.
  - `byte_done` pulses for one cycle at the end of the stop bit.
- **Widths.**
  - Bit counter: $clog2(CLKS_PER_BIT) bits.
  - Byte index: $clog2(NUM_BYTES+1) bits.
  - Index wrap is not possible: the index is compared against NUM_BYTES before it is incremented.
- **Reset values.** `tx_serial`=1, `tx_busy`=0, `tx_finish`=0, both FSMs idle, `start_q`=0, all counters 0.
- **Reset mid-frame.** `tx_serial` returns high on the next edge. The frame is truncated and no `tx_finish` is issued.
- **`start_tx` held high after `tx_finish`.** No new frame starts until `start_tx` has gone low and risen again.

## Timing
- The rising edge of `start_tx` is sampled at edge N.
- `tx_serial` goes low (start bit of HEADER) at edge N+2, after one cycle in LOAD. `tx_busy` rises at the same edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Inter-byte handoff (`byte_done` → LOAD → serializer start) must not insert idle-high time. The serializer starts the next start bit on the cycle right after the stop bit ends, so the next byte's `go` must be pre-registered to arrive in time.
- Total frame: exactly (NUM_BYTES+1)·10·CLKS_PER_BIT cycles of `tx_busy`=1.
- `tx_finish` is asserted on the first cycle after `tx_busy` falls, and is high for exactly 1 cycle.
- Controller interaction: the controller sees `tx_finish` and returns to IDLE at the next edge, dropping `start_tx`. This creates no new edge, so the block does not restart.

## Structure
- Shared package `peecc_pkg`:
  - UART framing constants (start bit 0, stop bit 1, 8 data bits).
  - Default HEADER value.
  - Top and byte FSM state enums.
- Sub-module `uart_tx_byte`:
  - Parameter: CLKS_PER_BIT.
  - Ports: `clk`, `reset`, `go`, `data[7:0]`, `tx_serial`, `byte_busy`, `byte_done`.
- `result_uart_tx` contains the frame sequencer, payload shift register and edge detector.

## Test plan
All scenarios use CLKS_PER_BIT=4 and NUM_BYTES=2.
- **Single frame.** `results`=16'h3C81, pulse `start_tx` high and hold it.
  - Expect the bytes A5, 81, 3C decoded from the line, LSB-first, each bit 4 cycles wide.
  - Expect `tx_busy` high for exactly 120 cycles, then `tx_finish` high for exactly 1 cycle.
- **Held start.** Keep `start_tx` high for 300 cycles.
  - Expect exactly one frame and exactly one `tx_finish`.
  - Drop `start_tx`, raise it again: expect a second frame.
- **Payload stability.** Change `results` to 16'hFFFF 5 cycles after start. Expect the payload to still decode as 81, 3C.
- **Mid-frame reset.** Assert `reset` for 1 cycle during the data bits of byte 1.
  - Expect `tx_serial`=1 and `tx_busy`=0 on the next edge.
  - Expect no `tx_finish`.
  - A subsequent start edge produces a full, correct frame.
- **Back-to-back bytes.** Expect no idle-high cycles between a stop bit and the next start bit. Check start-bit falling edges at cycle offsets 0, 40 and 80 from the first one.
- **Ignored re-trigger.** Toggle `start_tx` low then high during the frame. Expect no effect on the frame, and the block returns to IDLE after a single `tx_finish`.
